// File: rtl/uart_receiver.sv
// uart_receiver: APB-slave 8N1 UART receiver, oversampled at CPB clocks per bit.
// The last good byte is held in DATA (0x00); STATUS (0x01) = {overrun, frame_err, rx_valid}.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN, which adds
// a PARITY state and reports parity_err in STATUS bit 3.
module uart_receiver #(
    parameter int CPB = 87
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL2,
    input  logic       PENABLE,
    input  logic [7:0] PADDR,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    input  logic       i_Rx_Serial,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       o_Rx_Done,
    output logic       o_Rx_Irq
);

    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'((CPB - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            rx_meta_q, rx_s_q;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad_q;
    logic            parity_err_q, parity_err_d;
`endif

    logic            cnt_last, stop_ok, stop_bad;
    logic            acc, data_rd, status_wr;
    logic [7:0]      status;
    logic            unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign cnt_last = (clk_cnt_q == LAST);
    // Done is shown during the cycle whose closing edge stores the byte, so a DATA
    // read in that same cycle still sees the previous byte.
    assign stop_ok   = (state_q == S_STOP) && cnt_last && rx_s_q && !PRESET;
    assign stop_bad  = (state_q == S_STOP) && cnt_last && !rx_s_q;
    assign o_Rx_Done = stop_ok;

    assign acc       = PSEL2 & PENABLE;
    assign PREADY    = acc;
    assign data_rd   = acc & ~PWRITE & (PADDR == 8'h00);
    assign status_wr = acc &  PWRITE & (PADDR == 8'h01);

    // Frame FSM: start-bit qualification, LSB-first data shift, stop check, byte store
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (clk_cnt_q == HALF) begin
                        clk_cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_last) begin
                        clk_cnt_q    <= '0;
                        parity_bad_q <= (^shift_q) ^ rx_s_q;
                        state_q      <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_last) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    clk_cnt_q <= '0;
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    clk_cnt_q <= '0;
                end
            endcase
        end
    end

    // Status flag next-state: receive events take priority over bus clears
    always_comb begin
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (stop_ok) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q && !data_rd) overrun_d = 1'b1;
        end else if (data_rd) begin
            rx_valid_d = 1'b0;
        end
        if (status_wr && !(stop_ok && rx_valid_q && !data_rd)) overrun_d = 1'b0;
        if (stop_bad) frame_err_d = 1'b1;
        else if (status_wr) frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
        if (stop_ok && parity_bad_q) parity_err_d = 1'b1;
        else if (status_wr) parity_err_d = 1'b0;
`endif
    end

    // Status flag registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_Rx_Irq = rx_valid_q;

    // Read mux: register contents during a read access phase, zero otherwise
    always_comb begin
        status = {5'b0, overrun_q, frame_err_q, rx_valid_q};
`ifdef UART_RX_PARITY_EN
        status[3] = parity_err_q;
`endif
        PRDATA = 8'h00;
        if (acc && !PWRITE) begin
            case (PADDR)
                8'h00:   PRDATA = data_q;
                8'h01:   PRDATA = status;
                default: PRDATA = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver (default build, 8N1, CPB=87).
module tb_uart_receiver;

    localparam int CPB = 87;

    logic       PCLK = 1'b0;
    logic       PRESET, PSEL2, PENABLE, PWRITE, i_Rx_Serial;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY, o_Rx_Done, o_Rx_Irq;

    uart_receiver #(.CPB(CPB)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL2(PSEL2), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .i_Rx_Serial(i_Rx_Serial),
        .PRDATA(PRDATA), .PREADY(PREADY), .o_Rx_Done(o_Rx_Done), .o_Rx_Irq(o_Rx_Irq)
    );

    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rd_q[$];
    int         done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned fall_cyc = 0;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data on every read access phase, tracks done pulses
    always @(negedge PCLK) begin
        logic [7:0] exp;
        if (PSEL2 && PENABLE && !PWRITE) begin
            check("pready", PREADY, 1);
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", PRDATA);
            end else begin
                exp = rd_q.pop_front();
                check("prdata", PRDATA, exp);
            end
        end
        if (o_Rx_Done) begin
            check("done_width", prev_done, 0);
            if (!prev_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_done = o_Rx_Done;
    end

    task automatic apb_read(input logic [7:0] addr, input logic [7:0] exp);
        @(posedge PCLK); #1;
        PSEL2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        rd_q.push_back(exp);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL2 = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
        @(posedge PCLK); #1;
        PSEL2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; line is left at the stop value.
    task automatic send_frame(input logic [7:0] data, input logic stopv);
        @(posedge PCLK); #1;
        fall_cyc    = cyc;
        i_Rx_Serial = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge PCLK);
            #1 i_Rx_Serial = data[i];
        end
        repeat (CPB) @(posedge PCLK);
        #1 i_Rx_Serial = stopv;
        repeat (CPB) @(posedge PCLK);
        #1;
    endtask

    task automatic check_latency(input string name);
        int unsigned lat;
        lat = done_cyc - fall_cyc;
        n_cmp++;
        if (lat < 826 || lat > 829) begin
            n_bad++;
            $display("FAIL %s: got %0d cycles expected 826..829", name, lat);
        end
    endtask

    initial begin
        int d0;
        PRESET = 1'b1; PSEL2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 8'h00; i_Rx_Serial = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;

        // Reset state
        check("rst_irq", o_Rx_Irq, 0);
        apb_read(8'h00, 8'h00);
        apb_read(8'h01, 8'h00);
        apb_read(8'h07, 8'h00);
        check("rst_done_cnt", done_cnt, 0);

        // Single good frame
        d0 = done_cnt;
        send_frame(8'hCC, 1'b1);
        check("cc_done_cnt", done_cnt, d0 + 1);
        check_latency("cc_latency");
        check("cc_irq", o_Rx_Irq, 1);
        apb_read(8'h01, 8'h01);
        apb_read(8'h00, 8'hCC);
        apb_read(8'h01, 8'h00);
        check("cc_irq_clr", o_Rx_Irq, 0);

        // Short low glitch is rejected in START
        d0 = done_cnt;
        @(posedge PCLK); #1 i_Rx_Serial = 1'b0;
        repeat (20) @(posedge PCLK);
        #1 i_Rx_Serial = 1'b1;
        repeat (3 * CPB) @(posedge PCLK);
        check("glitch_done_cnt", done_cnt, d0);
        apb_read(8'h01, 8'h00);

        // Framing error followed by a held-low break
        d0 = done_cnt;
        send_frame(8'hA5, 1'b0);
        repeat (3 * CPB) @(posedge PCLK);
        check("ferr_done_low", done_cnt, d0);
        apb_read(8'h01, 8'h02);
        @(posedge PCLK); #1 i_Rx_Serial = 1'b1;
        repeat (12 * CPB) @(posedge PCLK);
        check("ferr_done_cnt", done_cnt, d0);
        apb_read(8'h01, 8'h02);
        apb_read(8'h00, 8'hCC);
        apb_write(8'h00, 8'h55);
        apb_write(8'h01, 8'hFF);
        apb_read(8'h01, 8'h00);
        apb_read(8'h00, 8'hCC);

        // Overrun, then a DATA read landing in the done cycle of a third frame
        d0 = done_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        apb_read(8'h01, 8'h05);
        fork
            send_frame(8'h33, 1'b1);
            begin
                @(posedge PCLK);
                repeat (827) @(posedge PCLK);
                apb_read(8'h00, 8'h22);
            end
            begin
                @(posedge PCLK);
                repeat (829) @(posedge PCLK);
                @(negedge PCLK);
                check("done_in_read_cycle", {o_Rx_Done, PENABLE}, 2'b11);
            end
        join
        check("ovr_done_cnt", done_cnt, d0 + 3);
        apb_read(8'h01, 8'h05);
        apb_read(8'h00, 8'h33);
        apb_read(8'h01, 8'h04);
        apb_write(8'h01, 8'h00);
        apb_read(8'h01, 8'h00);

        // Reset during bit 4, held past the end of the frame
        d0 = done_cnt;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                @(posedge PCLK);
                repeat (5 * CPB + 40) @(posedge PCLK);
                #1 PRESET = 1'b1;
                repeat (6 * CPB) @(posedge PCLK);
                #1 PRESET = 1'b0;
            end
        join
        check("rstmid_done_cnt", done_cnt, d0);
        apb_read(8'h00, 8'h00);
        apb_read(8'h01, 8'h00);
        send_frame(8'h3C, 1'b1);
        check("post_rst_done_cnt", done_cnt, d0 + 1);
        check_latency("3c_latency");
        apb_read(8'h01, 8'h01);
        apb_read(8'h00, 8'h3C);
        apb_read(8'h01, 8'h00);

        repeat (4) @(posedge PCLK);
        check("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
